// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_arbiter_pkg                                                        |
// | Port indices and SRAM-like bus widths shared by the request arbiter.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mem_req_arbiter_pkg;
    localparam int PORT_INST = 0;
    localparam int PORT_DATA = 1;
    localparam int NUM_PORTS = 2;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int STRB_W    = DATA_W / 8;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_id_t;
endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_arbiter_if                                                         |
// | SRAM-like request bus carrying N request ports and one shared read bus.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_req_arbiter_if #(
    parameter int N = 1
);
    import mem_req_arbiter_pkg::*;

    logic [N-1:0]        req;
    logic [N-1:0]        wr;
    logic [N*STRB_W-1:0] wstrb;
    logic [N*ADDR_W-1:0] addr;
    logic [N*DATA_W-1:0] wdata;
    logic [N-1:0]        addr_ok;
    logic [N-1:0]        data_ok;
    logic [DATA_W-1:0]   rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter_req_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | req_id_fifo                                                                |
// | In-order FIFO of 1-bit issuer IDs for accepted, unanswered transactions.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module req_id_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic i_push,
    input  wire logic i_push_data,
    input  wire logic i_pop,
    output logic      o_full,
    output logic      o_empty,
    output logic      o_head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem_q,    w_mem_d;
    logic [PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [PTR_W:0]   r_count_q,  w_count_d;

    // Caller guarantees no push when full and no pop when empty.
    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_push) begin
            w_mem_d[r_wr_ptr_q] = i_push_data;
            w_wr_ptr_d          = r_wr_ptr_q + 1'b1;
        end
        if (i_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({i_push, i_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_q    <= '0;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    assign o_full  = (r_count_q == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count_q == '0);
    assign o_head  = r_mem_q[r_rd_ptr_q];
endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_arbiter                                                            |
// | Shares one SRAM-like port between fetch (0) and load/store (1).            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic           clk,
    input  wire logic           resetn,
    mem_req_arbiter_if.slave    s_bus,
    mem_req_arbiter_if.master   m_bus,
    output logic                err_spurious
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic             r_lock_valid_q, w_lock_valid_d;
    port_id_t         r_lock_id_q,    w_lock_id_d;
    logic [CNT_W-1:0] r_starve_q,     w_starve_d;
    logic             r_err_q,        w_err_d;

    logic     w_grant_valid;
    port_id_t w_grant_id;
    port_id_t w_sel;
    logic     w_m_req;
    logic     w_push;
    logic     w_pop;
    logic     w_fifo_full;
    logic     w_fifo_empty;
    logic     w_fifo_head;
    logic     w_starved;

    assign w_starved = (r_starve_q == CNT_W'(STARVE_LIMIT));

    // Data port wins unless fetch has waited out its starvation budget.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = port_id_t'(PORT_INST);
        if (!w_fifo_full) begin
            if (s_bus.req[PORT_DATA] && !(s_bus.req[PORT_INST] && w_starved)) begin
                w_grant_valid = 1'b1;
                w_grant_id    = port_id_t'(PORT_DATA);
            end else if (s_bus.req[PORT_INST]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = port_id_t'(PORT_INST);
            end
        end
    end

    assign w_sel   = r_lock_valid_q ? r_lock_id_q : w_grant_id;
    assign w_m_req = resetn && (r_lock_valid_q || w_grant_valid);
    assign w_push  = w_m_req && m_bus.addr_ok;
    assign w_pop   = resetn && m_bus.data_ok && !w_fifo_empty;

    always_comb begin
        m_bus.req   = w_m_req;
        m_bus.wr    = '0;
        m_bus.wstrb = '0;
        m_bus.addr  = '0;
        m_bus.wdata = '0;
        if (w_m_req) begin
            m_bus.wr    = s_bus.wr[w_sel];
            m_bus.wstrb = s_bus.wstrb[int'(w_sel)*STRB_W +: STRB_W];
            m_bus.addr  = s_bus.addr[int'(w_sel)*ADDR_W +: ADDR_W];
            m_bus.wdata = s_bus.wdata[int'(w_sel)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        s_bus.addr_ok = '0;
        s_bus.data_ok = '0;
        s_bus.rdata   = '0;
        if (w_push) begin
            s_bus.addr_ok[w_sel] = 1'b1;
        end
        if (w_pop) begin
            s_bus.data_ok[w_fifo_head] = 1'b1;
            s_bus.rdata                = m_bus.rdata;
        end
    end

    always_comb begin
        w_lock_valid_d = r_lock_valid_q;
        w_lock_id_d    = r_lock_id_q;
        w_starve_d     = r_starve_q;
        w_err_d        = r_err_q | (m_bus.data_ok && w_fifo_empty);
        if (w_push) begin
            w_lock_valid_d = 1'b0;
        end else if (w_m_req && !r_lock_valid_q) begin
            w_lock_valid_d = 1'b1;
            w_lock_id_d    = w_grant_id;
        end
        if (!s_bus.req[PORT_INST] || s_bus.addr_ok[PORT_INST]) begin
            w_starve_d = '0;
        end else if (!w_starved) begin
            w_starve_d = r_starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock_valid_q <= 1'b0;
            r_lock_id_q    <= '0;
            r_starve_q     <= '0;
            r_err_q        <= 1'b0;
        end else begin
            r_lock_valid_q <= w_lock_valid_d;
            r_lock_id_q    <= w_lock_id_d;
            r_starve_q     <= w_starve_d;
            r_err_q        <= w_err_d;
        end
    end

    assign err_spurious = r_err_q;

    req_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_req_id_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_push_data (w_sel),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head)
    );
endmodule
`default_nettype wire
